// File: rtl/freq_meter_mc.sv
// Multi-channel frequency / period meter, single clock domain.
// Each channel counts edges per gate window or clk cycles per input period.
module freq_meter_mc #(
    parameter int CH          = 4,
    parameter int CNT_W       = 32,
    parameter int GATE_CYCLES = 62500000,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CH-1:0]       sig_in,
    input  logic [CH-1:0]       ena,
    input  logic [CH-1:0]       mode,
    output logic [CH*CNT_W-1:0] readout,
    output logic [CH-1:0]       readout_valid,
    output logic [CH-1:0]       readout_ovf,
    output logic                gate_tick
);

    localparam int GW = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] MAXV = '1;

    logic [GW-1:0]          gate_q, gate_d;
    logic                   tick;
    logic [SYNC_STAGES-1:0] sync_q [CH];
    logic [CH-1:0]          prev_q, edg_q;
    logic [CH-1:0]          mode_q;
    logic [CH-1:0]          armed_q, armed_d;
    logic [CH-1:0]          wf_q, wf_d;
    logic [CH-1:0]          acc_q, acc_d;
    logic [CH-1:0]          vld_q, vld_d;
    logic [CH-1:0]          rovf_q, rovf_d;
    logic [CNT_W-1:0]       cnt_q [CH];
    logic [CNT_W-1:0]       cnt_d [CH];
    logic [CNT_W-1:0]       rd_q [CH];
    logic [CNT_W-1:0]       rd_d [CH];
    logic [CNT_W-1:0]       cp [CH];

    always_comb begin
        tick   = (gate_q == GW'(GATE_CYCLES - 1));
        gate_d = tick ? '0 : gate_q + 1'b1;
    end

    // Frequency-mode count including this cycle's edge, saturating.
    always_comb begin
        for (int i = 0; i < CH; i++) begin
            cp[i] = cnt_q[i] + CNT_W'(edg_q[i] && (cnt_q[i] != MAXV));
        end
    end

    always_comb begin
        for (int i = 0; i < CH; i++) begin
            cnt_d[i]   = cnt_q[i];
            rd_d[i]    = rd_q[i];
            armed_d[i] = armed_q[i];
            wf_d[i]    = wf_q[i];
            acc_d[i]   = acc_q[i];
            vld_d[i]   = 1'b0;
            rovf_d[i]  = rovf_q[i];
            if (!ena[i] || (mode[i] != mode_q[i])) begin
                cnt_d[i]   = '0;
                armed_d[i] = 1'b0;
                wf_d[i]    = 1'b0;
                acc_d[i]   = 1'b0;
            end else if (!mode[i]) begin
                armed_d[i] = 1'b0;
                cnt_d[i]   = cp[i];
                acc_d[i]   = acc_q[i] | (cp[i] == MAXV);
                if (tick) begin
                    if (wf_q[i]) begin
                        rd_d[i]   = cp[i];
                        rovf_d[i] = acc_q[i] | (cp[i] == MAXV);
                        vld_d[i]  = 1'b1;
                    end
                    cnt_d[i] = '0;
                    acc_d[i] = 1'b0;
                    wf_d[i]  = 1'b1;
                end
            end else begin
                wf_d[i]  = 1'b0;
                acc_d[i] = 1'b0;
                if (edg_q[i]) begin
                    if (armed_q[i]) begin
                        rd_d[i]   = (cnt_q[i] == MAXV) ? MAXV : cnt_q[i] + 1'b1;
                        rovf_d[i] = (cnt_q[i] == MAXV);
                        vld_d[i]  = 1'b1;
                    end
                    armed_d[i] = 1'b1;
                    cnt_d[i]   = '0;
                end else if (armed_q[i]) begin
                    // No edge within the counter range: report timeout, disarm.
                    if (cnt_q[i] == MAXV) begin
                        rd_d[i]    = MAXV;
                        rovf_d[i]  = 1'b1;
                        vld_d[i]   = 1'b1;
                        armed_d[i] = 1'b0;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gate_q  <= '0;
            prev_q  <= '0;
            edg_q   <= '0;
            mode_q  <= '0;
            armed_q <= '0;
            wf_q    <= '0;
            acc_q   <= '0;
            vld_q   <= '0;
            rovf_q  <= '0;
            for (int i = 0; i < CH; i++) begin
                sync_q[i] <= '0;
                cnt_q[i]  <= '0;
                rd_q[i]   <= '0;
            end
        end else begin
            gate_q  <= gate_d;
            mode_q  <= mode;
            armed_q <= armed_d;
            wf_q    <= wf_d;
            acc_q   <= acc_d;
            vld_q   <= vld_d;
            rovf_q  <= rovf_d;
            for (int i = 0; i < CH; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], sig_in[i]};
                prev_q[i] <= sync_q[i][SYNC_STAGES-1];
                edg_q[i]  <= sync_q[i][SYNC_STAGES-1] & ~prev_q[i];
                cnt_q[i]  <= cnt_d[i];
                rd_q[i]   <= rd_d[i];
            end
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_out
        assign readout[g*CNT_W +: CNT_W] = rd_q[g];
    end

    assign readout_valid = vld_q;
    assign readout_ovf   = rovf_q;
    assign gate_tick     = tick;

endmodule

// File: tb/tb_freq_meter_mc.sv
// Directed bench for freq_meter_mc: a 32-bit and a 4-bit instance,
// both with two channels and a 100-cycle gate window.
module tb_freq_meter_mc;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] a_sig, a_ena, a_mode, a_vld, a_ovf;
    logic [1:0] b_sig, b_ena, b_mode, b_vld, b_ovf;
    logic [63:0] a_rd;
    logic [7:0]  b_rd;
    logic        a_tick, b_tick;
    logic s0 = 1'b0, s1 = 1'b0, s2 = 1'b0, s3 = 1'b0;
    logic g0 = 1'b0, g1 = 1'b0, g2 = 1'b0;
    int total = 0;
    int bad   = 0;
    int sc [4] = '{0, 0, 0, 0};

    assign a_sig = {s1, s0};
    assign b_sig = {s3, s2};

    always #5 clk = ~clk;

    freq_meter_mc #(
        .CH(2), .CNT_W(32), .GATE_CYCLES(100), .SYNC_STAGES(2)
    ) u_a (
        .clk(clk), .rst(rst), .sig_in(a_sig), .ena(a_ena), .mode(a_mode),
        .readout(a_rd), .readout_valid(a_vld), .readout_ovf(a_ovf),
        .gate_tick(a_tick)
    );

    freq_meter_mc #(
        .CH(2), .CNT_W(4), .GATE_CYCLES(100), .SYNC_STAGES(2)
    ) u_b (
        .clk(clk), .rst(rst), .sig_in(b_sig), .ena(b_ena), .mode(b_mode),
        .readout(b_rd), .readout_valid(b_vld), .readout_ovf(b_ovf),
        .gate_tick(b_tick)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic vbit(input int k);
        logic [3:0] v;
        v = {b_vld, a_vld};
        return v[k];
    endfunction

    task automatic wait_v(input int k, input int lim, output logic ok);
        int n;
        n = 0;
        while (!vbit(k) && n < lim) begin
            @(negedge clk);
            n++;
        end
        ok = vbit(k);
    endtask

    task automatic wait_tick(input int lim, output int n);
        n = 0;
        while (!a_tick && n < lim) begin
            @(negedge clk);
            n++;
        end
    endtask

    // strobe counters
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) sc[k] += int'(vbit(k));
    end

    // ch a0: toggle every 5 clk (period 10)
    initial begin
        int c;
        c = 0;
        forever begin
            @(negedge clk);
            if (g0) begin
                c++;
                if (c == 5) begin
                    c = 0;
                    s0 = ~s0;
                end
            end
        end
    end

    // ch a1: period 37 clk
    initial begin
        int c;
        c = 0;
        forever begin
            @(negedge clk);
            if (g1) begin
                s1 = (c < 18);
                c = (c == 36) ? 0 : c + 1;
            end
        end
    end

    // ch b0: rising edge every 2 clk
    initial begin
        forever begin
            @(negedge clk);
            if (g2) s2 = ~s2;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic ok;
        int   n, s;
        a_ena = 2'b11; a_mode = 2'b10;
        b_ena = 2'b11; b_mode = 2'b10;
        repeat (3) @(negedge clk);
        chk("rst_a_rd", a_rd, 64'd0);
        chk("rst_a_vld", a_vld, 2'b00);
        chk("rst_a_ovf", a_ovf, 2'b00);
        chk("rst_tick", a_tick, 1'b0);
        chk("rst_b_rd", b_rd, 8'd0);
        chk("rst_b_tick", b_tick, 1'b0);
        rst = 1'b0;
        g0 = 1'b1;
        g2 = 1'b1;

        // frequency mode: partial first window, then 10 edges per window
        wait_tick(200, n);
        chk("tick_first", n, 99);
        @(negedge clk);
        chk("a0_partial", a_vld[0], 1'b0);
        for (int w = 0; w < 2; w++) begin
            wait_tick(200, n);
            @(negedge clk);
            chk("a0_vld", a_vld[0], 1'b1);
            chk("a0_rd", a_rd[31:0], 32'd10);
            chk("a0_ovf", a_ovf[0], 1'b0);
            @(negedge clk);
            chk("a0_pulse", a_vld[0], 1'b0);
        end

        // period mode: first edge only arms
        g1 = 1'b1;
        s = sc[1];
        repeat (38) @(negedge clk);
        chk("a1_first", sc[1] - s, 0);
        for (int w = 0; w < 3; w++) begin
            wait_v(1, 60, ok);
            chk("a1_seen", ok, 1'b1);
            chk("a1_rd", a_rd[63:32], 32'd37);
            chk("a1_ovf", a_ovf[1], 1'b0);
            @(negedge clk);
            chk("a1_pulse", a_vld[1], 1'b0);
        end

        // 4-bit counter saturates in frequency mode
        for (int w = 0; w < 2; w++) begin
            wait_v(2, 250, ok);
            chk("b0_seen", ok, 1'b1);
            chk("b0_rd", b_rd[3:0], 4'd15);
            chk("b0_ovf", b_ovf[0], 1'b1);
            @(negedge clk);
        end

        // period timeout on the 4-bit instance
        chk("b1_quiet", sc[3], 0);
        s3 = 1'b1;
        repeat (3) @(negedge clk);
        s3 = 1'b0;
        wait_v(3, 40, ok);
        chk("b1_to_seen", ok, 1'b1);
        chk("b1_to_rd", b_rd[7:4], 4'd15);
        chk("b1_to_ovf", b_ovf[1], 1'b1);
        s = sc[3];
        repeat (40) @(negedge clk);
        chk("b1_to_once", sc[3] - s, 1);
        s = sc[3];
        s3 = 1'b1;
        repeat (3) @(negedge clk);
        s3 = 1'b0;
        repeat (7) @(negedge clk);
        chk("b1_rearm", sc[3] - s, 0);
        s3 = 1'b1;
        wait_v(3, 20, ok);
        chk("b1_per_seen", ok, 1'b1);
        chk("b1_per_rd", b_rd[7:4], 4'd10);
        chk("b1_per_ovf", b_ovf[1], 1'b0);
        repeat (3) @(negedge clk);
        s3 = 1'b0;

        // mode flip mid-window discards that window
        wait_v(0, 150, ok);
        chk("a0_pre", ok, 1'b1);
        repeat (30) @(negedge clk);
        a_mode[0] = 1'b1;
        repeat (5) @(negedge clk);
        a_mode[0] = 1'b0;
        s = sc[0];
        wait_tick(200, n);
        repeat (2) @(negedge clk);
        chk("a0_mchg_none", sc[0] - s, 0);
        chk("a0_mchg_hold", a_rd[31:0], 32'd10);
        wait_v(0, 150, ok);
        chk("a0_mchg_seen", ok, 1'b1);
        chk("a0_mchg_rd", a_rd[31:0], 32'd10);
        chk("a0_mchg_ovf", a_ovf[0], 1'b0);

        // rst pulse mid-window, channel a0 disabled for 300 cycles
        repeat (30) @(negedge clk);
        rst = 1'b1;
        a_ena[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("rst2_a_rd", a_rd, 64'd0);
        chk("rst2_a_vld", a_vld, 2'b00);
        chk("rst2_a_ovf", a_ovf, 2'b00);
        chk("rst2_b_rd", b_rd, 8'd0);
        chk("rst2_tick", a_tick, 1'b0);
        s = sc[0];
        wait_tick(200, n);
        chk("rst2_tick_n", n, 99);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!a_tick && n < 200);
        chk("tick_period", n, 100);
        repeat (101) @(negedge clk);
        chk("dis_none", sc[0] - s, 0);
        chk("dis_hold", a_rd[31:0], 32'd0);
        a_ena[0] = 1'b1;
        wait_tick(200, n);
        @(negedge clk);
        chk("ena_partial", a_vld[0], 1'b0);
        wait_v(0, 150, ok);
        chk("ena_seen", ok, 1'b1);
        chk("ena_rd", a_rd[31:0], 32'd10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
